// File: rtl/subst_pkg.sv
// Shared types and constants for the substitution codec: controller states,
// stream mode encodings and the ASCII letters of the default ETAOINSHRDLU key.
package subst_pkg;

  typedef enum logic [2:0] {
    EMPTY = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    RUN   = 3'd3,
    ERROR = 3'd4
  } SUBST_STATE_T;

  localparam logic MODE_DEC = 1'b0;
  localparam logic MODE_ENC = 1'b1;

  localparam logic [7:0] CH_A = 8'h41;
  localparam logic [7:0] CH_D = 8'h44;
  localparam logic [7:0] CH_E = 8'h45;
  localparam logic [7:0] CH_H = 8'h48;
  localparam logic [7:0] CH_I = 8'h49;
  localparam logic [7:0] CH_L = 8'h4C;
  localparam logic [7:0] CH_N = 8'h4E;
  localparam logic [7:0] CH_O = 8'h4F;
  localparam logic [7:0] CH_R = 8'h52;
  localparam logic [7:0] CH_S = 8'h53;
  localparam logic [7:0] CH_T = 8'h54;
  localparam logic [7:0] CH_U = 8'h55;
  localparam logic [7:0] CH_Z = 8'h5A;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/subst_cam.sv
// Combinational search of one key column; reports whether the value is present
// and the lowest index holding it.
module subst_cam #(
  parameter int DATA_W  = 8,
  parameter int ALPHA_N = 12,
  parameter int IDX_W   = $clog2(ALPHA_N)
) (
  input  logic [DATA_W-1:0] keys [ALPHA_N],
  input  logic [DATA_W-1:0] value,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  // Priority search: the first matching entry wins.
  always_comb begin
    hit = 1'b0;
    idx = {IDX_W{1'b0}};
    for (int i = 0; i < ALPHA_N; i++) begin
      idx = (!hit && (keys[i] == value)) ? IDX_W'(i) : idx;
      hit = hit | (keys[i] == value);
    end
  end

endmodule

// File: rtl/subst_codec.sv
// Streaming monoalphabetic substitution codec with a loadable, self-checked key
// table. Define SUBST_CODEC_STATS_EN to add saturating hit/miss beat counters.
module subst_codec
  import subst_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ALPHA_N = 12,
  localparam int IDX_W  = $clog2(ALPHA_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_we,
  input  logic [IDX_W-1:0]  key_idx,
  input  logic [DATA_W-1:0] key_plain,
  input  logic [DATA_W-1:0] key_cipher,
  input  logic              key_commit,
  output logic              key_ok,
  output logic              key_err,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_miss
`ifdef SUBST_CODEC_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);

  SUBST_STATE_T      state_r, next_s;
  logic [DATA_W-1:0] plain_r  [ALPHA_N];
  logic [DATA_W-1:0] cipher_r [ALPHA_N];
  logic [ALPHA_N-1:0] written_r;
  logic [IDX_W-1:0]  chk_idx_r;
  logic              we_s, chk_fail_s, chk_last_s, accept_s;
  logic              key_ok_r, key_err_r, out_valid_r, out_miss_r;
  logic [DATA_W-1:0] out_data_r, result_s;
  logic              hit_p_s, hit_c_s, hit_s;
  logic [IDX_W-1:0]  idx_p_s, idx_c_s;

  assign we_s       = key_we && (int'(key_idx) < ALPHA_N);
  assign chk_last_s = (int'(chk_idx_r) == ALPHA_N - 1);

  // Key table storage; writes are accepted in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ALPHA_N; i++) begin
        plain_r[i]  <= {DATA_W{1'b0}};
        cipher_r[i] <= {DATA_W{1'b0}};
      end
      written_r <= {ALPHA_N{1'b0}};
    end else if (we_s) begin
      plain_r[key_idx]   <= key_plain;
      cipher_r[key_idx]  <= key_cipher;
      written_r[key_idx] <= 1'b1;
    end
  end

  // Entry under check must be written and unique against every later entry.
  always_comb begin
    chk_fail_s = !written_r[chk_idx_r];
    for (int j = 0; j < ALPHA_N; j++) begin
      chk_fail_s = chk_fail_s | ((j > int'(chk_idx_r)) &&
                   ((plain_r[j] == plain_r[chk_idx_r]) ||
                    (cipher_r[j] == cipher_r[chk_idx_r])));
    end
  end

  // Next-state logic of the key controller.
  always_comb begin
    next_s = state_r;
    case (state_r)
      EMPTY: begin
        if (we_s) next_s = LOAD;
        else      next_s = EMPTY;
      end
      LOAD: begin
        if (key_commit) next_s = CHECK;
        else            next_s = LOAD;
      end
      CHECK: begin
        if (we_s)            next_s = LOAD;
        else if (chk_fail_s) next_s = ERROR;
        else if (chk_last_s) next_s = RUN;
        else                 next_s = CHECK;
      end
      RUN, ERROR: begin
        if (we_s) next_s = LOAD;
        else      next_s = state_r;
      end
      default: next_s = EMPTY;
    endcase
  end

  // Controller state, check index and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= EMPTY;
      chk_idx_r <= {IDX_W{1'b0}};
      key_ok_r  <= 1'b0;
      key_err_r <= 1'b0;
    end else begin
      state_r   <= next_s;
      chk_idx_r <= (state_r == CHECK) ? chk_idx_r + IDX_W'(1) : {IDX_W{1'b0}};
      key_ok_r  <= (next_s == RUN);
      key_err_r <= (next_s == ERROR);
    end
  end

  subst_cam #(.DATA_W(DATA_W), .ALPHA_N(ALPHA_N), .IDX_W(IDX_W)) u_cam_plain (
    .keys  (plain_r),
    .value (in_data),
    .hit   (hit_p_s),
    .idx   (idx_p_s)
  );

  subst_cam #(.DATA_W(DATA_W), .ALPHA_N(ALPHA_N), .IDX_W(IDX_W)) u_cam_cipher (
    .keys  (cipher_r),
    .value (in_data),
    .hit   (hit_c_s),
    .idx   (idx_c_s)
  );

  // Encode looks up the plain column, decode the cipher column; misses pass through.
  always_comb begin
    hit_s    = 1'b0;
    result_s = in_data;
    if (mode == MODE_ENC) begin
      hit_s    = hit_p_s;
      result_s = hit_p_s ? cipher_r[idx_p_s] : in_data;
    end else begin
      hit_s    = hit_c_s;
      result_s = hit_c_s ? plain_r[idx_c_s] : in_data;
    end
  end

  assign in_ready = (state_r == RUN) && (!out_valid_r || out_ready);
  assign accept_s = in_valid && in_ready;

  // Output register: loads on accept, empties on drain, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      out_miss_r  <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= result_s;
      out_miss_r  <= !hit_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign key_ok    = key_ok_r;
  assign key_err   = key_err_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_miss  = out_miss_r;

`ifdef SUBST_CODEC_STATS_EN
  logic [15:0] hit_cnt_r, miss_cnt_r;

  // Beat statistics restart whenever a new table check begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_r  <= 16'd0;
      miss_cnt_r <= 16'd0;
    end else if ((state_r != CHECK) && (next_s == CHECK)) begin
      hit_cnt_r  <= 16'd0;
      miss_cnt_r <= 16'd0;
    end else if (accept_s) begin
      if (hit_s) hit_cnt_r  <= sat_inc16(hit_cnt_r);
      else       miss_cnt_r <= sat_inc16(miss_cnt_r);
    end
  end

  assign hit_cnt  = hit_cnt_r;
  assign miss_cnt = miss_cnt_r;
`endif

endmodule

// File: tb/tb_subst_codec.sv
// Scoreboard bench for subst_codec: a reference lookup model predicts each
// accepted beat, and the prediction is compared when the beat drains.
`timescale 1ns/1ps
module tb_subst_codec;
  import subst_pkg::*;

  localparam int ALPHA_N = 12;
  localparam int IDX_W   = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic key_we = 1'b0, key_commit = 1'b0, mode = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic [IDX_W-1:0] key_idx = '0;
  logic [7:0] key_plain = '0, key_cipher = '0, in_data = '0;
  logic key_ok, key_err, in_ready, out_valid, out_miss;
  logic [7:0] out_data;
`ifdef SUBST_CODEC_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n, t0;
  logic [7:0] m_plain  [ALPHA_N];
  logic [7:0] m_cipher [ALPHA_N];
  logic [8:0] sb_q [$];
  logic [8:0] exp_v;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  logic [7:0] def_cipher [ALPHA_N] = '{CH_E, CH_T, CH_A, CH_O, CH_I, CH_N,
                                       CH_S, CH_H, CH_R, CH_D, CH_L, CH_U};
  logic [7:0] def_plain  [ALPHA_N] = '{CH_U, CH_N, CH_T, CH_I, CH_E, CH_H,
                                       CH_R, CH_A, CH_L, CH_S, CH_D, CH_O};
  logic [7:0] stim [8] = '{CH_E, CH_U, CH_T, CH_N, CH_Z, CH_A, CH_L, 8'h30};

  subst_codec dut (
    .clk(clk), .rst_n(rst_n),
    .key_we(key_we), .key_idx(key_idx), .key_plain(key_plain),
    .key_cipher(key_cipher), .key_commit(key_commit),
    .key_ok(key_ok), .key_err(key_err),
    .mode(mode), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_miss(out_miss)
`ifdef SUBST_CODEC_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic m, input logic [7:0] d);
    for (int i = 0; i < ALPHA_N; i++) begin
      if (m == MODE_DEC && m_cipher[i] == d) return {1'b0, m_plain[i]};
      if (m == MODE_ENC && m_plain[i] == d) return {1'b0, m_cipher[i]};
    end
    return {1'b1, d};
  endfunction

  // Scoreboard: predictions pushed on accept, compared on drain; stall stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && prev_stall) check("stall_hold", out_data, prev_data);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          exp_v = sb_q.pop_front();
          check("out_data", out_data, exp_v[7:0]);
          check("out_miss", out_miss, exp_v[8]);
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(mode, in_data));
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_key(input int idx, input logic [7:0] p, input logic [7:0] c);
    key_we = 1'b1; key_idx = IDX_W'(idx); key_plain = p; key_cipher = c;
    tick();
    key_we = 1'b0;
    m_plain[idx] = p; m_cipher[idx] = c;
  endtask

  task automatic commit_wait(output int cnt);
    key_commit = 1'b1;
    tick();
    key_commit = 1'b0;
    cnt = 0;
    while (!key_ok && !key_err && cnt < 40) begin
      tick();
      cnt++;
    end
  endtask

  task automatic send(input logic m, input logic [7:0] d);
    bit done = 1'b0;
    mode = m; in_data = d; in_valid = 1'b1;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 0, 1);
  endtask

  initial begin
    for (int i = 0; i < ALPHA_N; i++) begin m_plain[i] = 8'h00; m_cipher[i] = 8'h00; end
    repeat (3) @(posedge clk);
    #1;
    check("rst_key_ok", key_ok, 0);
    check("rst_key_err", key_err, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_miss", out_miss, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    tick();

    // Default key, commit latency, first decode
    for (int i = 0; i < ALPHA_N; i++) write_key(i, def_plain[i], def_cipher[i]);
    commit_wait(n);
    check("t1_ok_latency", n, 12);
    check("t1_key_ok", key_ok, 1);
    send(MODE_DEC, CH_E);
    in_valid = 1'b0;
    check("t1_lat_valid", out_valid, 1);
    tick();

    // Encode and miss
    send(MODE_ENC, CH_U);
    send(MODE_DEC, CH_Z);
    in_valid = 1'b0;
    repeat (2) tick();

    // Back-to-back stream with a 3-cycle sink stall
    t0 = cyc;
    fork
      begin
        for (int b = 0; b < 8; b++) send(b[0] ? MODE_ENC : MODE_DEC, stim[b]);
        in_valid = 1'b0;
      end
      begin
        repeat (3) tick();
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
      end
    join
    check("t3_cycles", cyc - t0, 11);
    repeat (3) tick();
    check("t3_drained", sb_q.size(), 0);

    // Duplicate cipher in entries 3 and 7
    for (int i = 0; i < ALPHA_N; i++) begin
      if (i == 2)      write_key(i, def_plain[i], CH_O);
      else if (i == 3) write_key(i, def_plain[i], 8'h41);
      else if (i == 7) write_key(i, def_plain[i], 8'h41);
      else             write_key(i, def_plain[i], def_cipher[i]);
      if (i == 0) check("t4_ok_drop", key_ok, 0);
    end
    commit_wait(n);
    check("t4_key_err", key_err, 1);
    check("t4_key_ok", key_ok, 0);
    in_valid = 1'b1; in_data = CH_E;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    write_key(7, CH_A, CH_H);
    check("t4_err_clear", key_err, 0);
    commit_wait(n);
    check("t4_ok_latency", n, 12);
    check("t4_key_ok", key_ok, 1);
    send(MODE_DEC, CH_A);
    in_valid = 1'b0;
    repeat (3) tick();

    // Asynchronous reset with a stalled pending beat
    out_ready = 1'b0;
    send(MODE_DEC, CH_T);
    in_valid = 1'b0;
    tick();
    check("t6_pending", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t6_valid_drop", out_valid, 0);
    check("t6_ok_drop", key_ok, 0);
    check("t6_ready_drop", in_ready, 0);
    sb_q.delete();
    for (int i = 0; i < ALPHA_N; i++) begin m_plain[i] = 8'h00; m_cipher[i] = 8'h00; end
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("t6_empty_ok", key_ok, 0);
    check("t6_empty_err", key_err, 0);
    check("t6_empty_ready", in_ready, 0);
    key_commit = 1'b1;
    tick();
    key_commit = 1'b0;
    repeat (15) tick();
    check("t6_commit_ignored", {key_ok, key_err}, 2'b00);

    // Unwritten entry 11, then a write aborting the check
    for (int i = 0; i < ALPHA_N - 1; i++) write_key(i, def_plain[i], def_cipher[i]);
    commit_wait(n);
    check("t5_key_err", key_err, 1);
    check("t5_key_ok", key_ok, 0);
    write_key(11, def_plain[11], def_cipher[11]);
    key_commit = 1'b1;
    tick();
    key_commit = 1'b0;
    repeat (3) tick();
    write_key(0, def_plain[0], def_cipher[0]);
    repeat (20) tick();
    check("t5_abort_ok", key_ok, 0);
    check("t5_abort_err", key_err, 0);
    commit_wait(n);
    check("t5_ok_latency", n, 12);
    send(MODE_ENC, CH_O);
    in_valid = 1'b0;
    repeat (3) tick();
    check("final_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/subst_codec.md
Name: subst_codec

Overview:
- Streaming, parametrised monoalphabetic substitution codec with a run-time programmable key table of ALPHA_N letter pairs.
- Each beat selects decode (cipher->plain) or encode (plain->cipher) on MODE.
- Sits between the character source and the text sink on a valid/ready byte stream.
- Replaces the fixed 12-letter hard-wired decoder with a loadable, self-checking table and registered output.

Parameters:
- DATA_W, 8: character width in bits.
- ALPHA_N, 12: number of key entries (letter pairs).
- IDX_W, $clog2(ALPHA_N): key index width; localparam, not overridable.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- KEY_WE  in  1  write key entry KEY_IDX.
- KEY_IDX  in  IDX_W  entry index; values >= ALPHA_N are ignored.
- KEY_PLAIN  in  DATA_W  plain character of the entry.
- KEY_CIPHER  in  DATA_W  cipher character of the entry.
- KEY_COMMIT  in  1  pulse to end loading and start the table check.
- KEY_OK  out  1  table validated; stream running.
- KEY_ERR  out  1  table invalid (duplicate or unwritten entry).
- MODE  in  1  0 = decode, 1 = encode; sampled with IN_DATA.
- IN_VALID  in  1  input beat valid.
- IN_READY  out  1  input beat accepted when IN_VALID and IN_READY are both high.
- IN_DATA  in  DATA_W  input character.
- OUT_VALID  out  1  output beat valid.
- OUT_READY  in  1  sink ready.
- OUT_DATA  out  DATA_W  translated character.
- OUT_MISS  out  1  character not in table; passed through unchanged.

Behaviour:
- Reset is asynchronous and active-low on RST_N; single clock CLK.
- Reset values:
  - state = EMPTY.
  - Key table and written mask cleared.
  - KEY_OK = 0, KEY_ERR = 0.
  - OUT_VALID = 0, OUT_DATA = 0, OUT_MISS = 0.
  - IN_READY = 0.
- FSM states EMPTY, LOAD, CHECK, RUN, ERROR:
  - EMPTY --KEY_WE--> LOAD.
  - LOAD: each KEY_WE writes both columns and sets written[idx]; rewriting an index overwrites it.
  - LOAD --KEY_COMMIT--> CHECK with check counter i = 0.
  - KEY_COMMIT in EMPTY is ignored.
  - CHECK: one cycle per i. Entry i's plain and cipher are each compared against all entries j > i in the same column. The check also fails if written[i] = 0.
  - On any failure in CHECK -> ERROR. If i = ALPHA_N-1 passes -> RUN. CHECK takes exactly ALPHA_N cycles.
  - ERROR: KEY_ERR = 1, IN_READY = 0. KEY_WE -> LOAD and clears KEY_ERR; the table is retained.
  - RUN: KEY_OK = 1. KEY_WE -> LOAD and drops KEY_OK the next cycle; the written mask is kept.
  - KEY_WE in CHECK aborts the check -> LOAD, and the write takes effect.
- Stream:
  - IN_READY = (state == RUN) && (!OUT_VALID || OUT_READY).
  - Accept -> 1-cycle latency. The output register loads the lookup result and OUT_VALID is set.
  - Decode mode searches the cipher column and returns plain; encode mode searches the plain column and returns cipher.
  - At most one match is guaranteed by CHECK; priority is lowest index.
  - Miss: OUT_DATA = IN_DATA, OUT_MISS = 1.
  - OUT_VALID clears on OUT_READY without a new accept.
  - Simultaneous accept and drain: the register is overwritten, giving full throughput of 1 beat/cycle.
  - Output held stable while OUT_VALID && !OUT_READY.
- Leaving RUN (KEY_WE): a pending output beat stays valid until drained and is not altered. No new accepts occur.
- Reset mid-stream discards the pending beat and returns to EMPTY; a key reload is required.

Optional Feature:
- Macro SUBST_CODEC_STATS_EN.
- Defined: adds outputs HIT_CNT[15:0] and MISS_CNT[15:0].
  - Each counts accepted beats by hit/miss and saturates at 16'hFFFF.
  - Both clear on reset and on entry to CHECK.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package subst_pkg:
  - state enum type SUBST_STATE_T (EMPTY, LOAD, CHECK, RUN, ERROR).
  - mode constants MODE_DEC = 1'b0, MODE_ENC = 1'b1.
  - ASCII letter constants used by benches for the default ETAOINSHRDLU key.
- Sub-module subst_cam:
  - Purely combinational search of one column.
  - Inputs: key column array and search value.
  - Outputs: hit and hit index.
  - Instantiated twice (plain column, cipher column); MODE selects which result is used.

Test Plan:
1. Load the 12 pairs (cipher->plain) E->U, T->N, A->T, O->I, I->E, N->H, S->R, H->A, R->L, D->S, L->D, U->O; commit -> KEY_OK rises exactly 12 cycles after KEY_COMMIT. Decode 8'h45 -> OUT_DATA 8'h55 one cycle after accept, OUT_MISS 0.
2. Same key: encode 8'h55 -> 8'h45. Decode 8'h5A ('Z') -> OUT_DATA 8'h5A, OUT_MISS 1.
3. Back-to-back stream of 8 beats with OUT_READY held low for 3 cycles mid-stream -> no loss or duplication, OUT_DATA stable while stalled, 1 beat/cycle otherwise.
4. Load with entries 3 and 7 sharing cipher 8'h41 -> KEY_ERR = 1, IN_READY stays 0. Rewrite entry 7 and recommit -> KEY_OK.
5. Commit with entry 11 never written -> ERROR. KEY_WE during CHECK -> back to LOAD, no KEY_OK.
6. Assert RST_N low with OUT_VALID = 1 and OUT_READY = 0 -> OUT_VALID, KEY_OK and IN_READY drop immediately (asynchronous); state is EMPTY after release.
